heat_chain: RTL and testbench

Parametrised 1D explicit-diffusion solver holding a chain of `NODES` fixed-point node values. On `start` it runs `steps` explicit time steps of u_i ← u_i + coef·(u_{i-1} − 2u_i + u_{i+1}), sweeping one node per clock through a single shared multiply-add datapath. It generalises the single-node update cell into a self-sequencing array with loadable state, selectable boundary conditions, saturation and a start/done handshake. It sits under the host/controller that loads initial conditions and reads back results.

---
 rtl/heat_chain.sv | 192 +++++++++++++++++++
 tb/tb_heat_chain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heat_chain.sv
// heat_chain: 1D explicit heat-diffusion solver over a chain of NODES
// fixed-point values. One node is updated per clock through one shared
// multiply-add datapath. Each step sweeps idx 0..NODES-1 in place.
//
// Handshake: start is sampled only in IDLE. An accepted start latches coef
// and steps and clears step_count and sat_flag. busy is high for exactly
// steps*NODES cycles, then done pulses high for one cycle with busy low.
// While busy (or done), start and wr_en are ignored. rd_data is always live.
module heat_chain #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int NODES   = 8,
    parameter int BC_MODE = 0,
    localparam int AW     = $clog2(NODES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] coef,
    input  logic [15:0]      steps,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      step_count,
    output logic             sat_flag
);

    localparam int AW1 = AW + 1;
    localparam int LW  = WIDTH + 2;      // laplacian width
    localparam int PW  = 2 * WIDTH + 2;  // product / sum width
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  coef_q, coef_d;
    logic [15:0]       steps_q, steps_d;
    logic [15:0]       step_count_q, step_count_d;
    logic              sat_q, sat_d;
    logic [WIDTH-1:0]  mem_q [NODES];
    logic [WIDTH-1:0]  mem_d [NODES];

    logic [WIDTH-1:0]  cur, nxt, left_nb, right_nb, upd;
    logic [AW:0]       idx_p1;
    logic              is_first, is_last, clamp;
    logic signed [LW-1:0] lap;
    logic signed [PW-1:0] prod, shifted, sum;

    assign idx_p1   = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
    assign is_first = (idx_q == '0);
    assign is_last  = (idx_q == AW'(NODES - 1));

    assign busy       = (state_q == ST_SWEEP);
    assign done       = (state_q == ST_DONE);
    assign step_count = step_count_q;
    assign sat_flag   = sat_q;

    // Fetch the node being updated and its right neighbour (still old-time).
    always_comb begin
        cur = '0;
        nxt = '0;
        for (int i = 0; i < NODES; i++) begin
            if (idx_q == AW'(i))   cur = mem_q[i];
            if (idx_p1 == AW1'(i)) nxt = mem_q[i];
        end
    end

    // Neighbour selection; at the ends the mirrored ghost values are used.
    always_comb begin
        left_nb  = prev_q;
        right_nb = nxt;
        if (is_first) left_nb  = nxt;     // ghost u_{-1} = u_1
        if (is_last)  right_nb = prev_q;  // ghost u_N = u_{N-2}, pre-update copy
    end

    // Shared multiply-add: cur + (coef * laplacian) >>> FRAC, then clamp.
    always_comb begin
        lap = $signed({{2{left_nb[WIDTH-1]}}, left_nb})
            - $signed({cur[WIDTH-1], cur, 1'b0})
            + $signed({{2{right_nb[WIDTH-1]}}, right_nb});
        prod = $signed({{(PW-WIDTH){coef_q[WIDTH-1]}}, coef_q})
             * $signed({{(PW-LW){lap[LW-1]}}, lap});
        shifted = prod >>> FRAC;
        sum = $signed({{(PW-WIDTH){cur[WIDTH-1]}}, cur}) + shifted;
        clamp = 1'b0;
        upd   = sum[WIDTH-1:0];
        if (sum > SAT_MAX) begin
            upd   = SAT_MAX[WIDTH-1:0];
            clamp = 1'b1;
        end else if (sum < SAT_MIN) begin
            upd   = SAT_MIN[WIDTH-1:0];
            clamp = 1'b1;
        end
        // Fixed-value ends simply write back what they held.
        if ((BC_MODE == 0) && (is_first || is_last)) begin
            upd   = cur;
            clamp = 1'b0;
        end
    end

    // Live readback port; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NODES; i++) begin
            if (rd_addr == AW'(i)) rd_data = mem_q[i];
        end
    end

    // Next-state logic for the IDLE/SWEEP/DONE sequencer and node memory.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        prev_d       = prev_q;
        coef_d       = coef_q;
        steps_d      = steps_q;
        step_count_d = step_count_q;
        sat_d        = sat_q;
        mem_d        = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    for (int i = 0; i < NODES; i++) begin
                        if (wr_addr == AW'(i)) mem_d[i] = wr_data;
                    end
                end
                if (start) begin
                    coef_d       = coef;
                    steps_d      = steps;
                    step_count_d = '0;
                    sat_d        = 1'b0;
                    idx_d        = '0;
                    state_d      = (steps != 16'd0) ? ST_SWEEP : ST_DONE;
                end
            end
            ST_SWEEP: begin
                for (int i = 0; i < NODES; i++) begin
                    if (idx_q == AW'(i)) mem_d[i] = upd;
                end
                prev_d = cur;
                if (clamp) sat_d = 1'b1;
                if (is_last) begin
                    step_count_d = step_count_q + 16'd1;
                    idx_d        = '0;
                    if (step_count_d == steps_q) state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            prev_q       <= '0;
            coef_q       <= '0;
            steps_q      <= '0;
            step_count_q <= '0;
            sat_q        <= 1'b0;
            for (int i = 0; i < NODES; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            prev_q       <= prev_d;
            coef_q       <= coef_d;
            steps_q      <= steps_d;
            step_count_q <= step_count_d;
            sat_q        <= sat_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_heat_chain.sv
// Bench for heat_chain: a fixed-end and an insulated-end instance (NODES=5)
// share all inputs; each is checked against hand-computed node values.
module tb_heat_chain;

  localparam int W = 32;
  localparam int N = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [2:0]    rd_addr;
  logic [W-1:0]  rd_data_d, rd_data_n;
  logic [W-1:0]  coef;
  logic [15:0]   steps;
  logic          start;
  logic          busy_d, busy_n, done_d, done_n, sat_d, sat_n;
  logic [15:0]   sc_d, sc_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [0:4][31:0] init;
    logic [31:0]      coef;
    logic [15:0]      steps;
    logic [0:4][31:0] exp_d;
    logic [0:4][31:0] exp_n;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[5];

  heat_chain #(.WIDTH(W), .FRAC(16), .NODES(N), .BC_MODE(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_d), .coef(coef), .steps(steps), .start(start),
    .busy(busy_d), .done(done_d), .step_count(sc_d), .sat_flag(sat_d)
  );

  heat_chain #(.WIDTH(W), .FRAC(16), .NODES(N), .BC_MODE(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .coef(coef), .steps(steps), .start(start),
    .busy(busy_n), .done(done_n), .step_count(sc_n), .sat_flag(sat_n)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic load(input logic [0:4][31:0] v);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = v[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] c, input logic [15:0] s);
    @(posedge clk); #1;
    coef = c; steps = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [0:4][31:0] ed, input logic [0:4][31:0] en);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(ed[i]);
      exp_q.push_back(en[i]);
    end
  endtask

  // scoreboard: read back every node of both instances against exp_q
  task automatic check_nodes(input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      rd_addr = 3'(i);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s:d_node%0d", tag, i), rd_data_d, e);
      e = exp_q.pop_front();
      check($sformatf("%s:n_node%0d", tag, i), rd_data_n, e);
    end
  endtask

  task automatic run_and_check(input logic [31:0] c, input logic [15:0] s,
                               input logic exp_sat, input string tag);
    int lat;
    start_run(c, s);
    check({tag, ":busy_after_start"}, {31'b0, busy_d}, (s != 16'd0) ? 32'd1 : 32'd0);
    lat = 0;
    while (done_d !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat + 1), 32'(int'(s) * N + 1));
    check({tag, ":done_n"}, {31'b0, done_n}, 32'd1);
    check({tag, ":busy_at_done"}, {31'b0, busy_d}, 32'd0);
    check({tag, ":step_count_d"}, {16'b0, sc_d}, {16'b0, s});
    check({tag, ":step_count_n"}, {16'b0, sc_n}, {16'b0, s});
    check({tag, ":sat_d"}, {31'b0, sat_d}, {31'b0, exp_sat});
    check({tag, ":sat_n"}, {31'b0, sat_n}, {31'b0, exp_sat});
    @(posedge clk); #1;
    check({tag, ":done_one_cycle"}, {31'b0, done_d}, 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;

    // vector table: {init, coef, steps, expected fixed-end, expected insulated, sat}
    vecs[0].init  = {32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0};
    vecs[0].coef  = 32'h00004000; vecs[0].steps = 16'd1;
    vecs[0].exp_d = {32'h0, 32'h00010000, 32'h00020000, 32'h00010000, 32'h0};
    vecs[0].exp_n = {32'h0, 32'h00010000, 32'h00020000, 32'h00010000, 32'h0};
    vecs[0].exp_sat = 1'b0;

    vecs[1].init  = {32'h0, 32'h0, 32'h00040000, 32'h0, 32'h0};
    vecs[1].coef  = 32'h00004000; vecs[1].steps = 16'd3;
    vecs[1].exp_d = {32'h0, 32'h0000E000, 32'h00014000, 32'h0000E000, 32'h0};
    vecs[1].exp_n = {32'h0000C000, 32'h00010000, 32'h00014000, 32'h00010000, 32'h0000C000};
    vecs[1].exp_sat = 1'b0;

    // -0.5 LSB must floor to -1 LSB
    vecs[2].init  = {32'h0, 32'h0, 32'h00000001, 32'h0, 32'h0};
    vecs[2].coef  = 32'h00004000; vecs[2].steps = 16'd1;
    vecs[2].exp_d = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2].exp_n = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2].exp_sat = 1'b0;

    vecs[3].init  = {32'hFFFF0000, 32'h0, 32'h0, 32'h0, 32'h00020000};
    vecs[3].coef  = 32'h00008000; vecs[3].steps = 16'd1;
    vecs[3].exp_d = {32'hFFFF0000, 32'hFFFF8000, 32'h0, 32'h00010000, 32'h00020000};
    vecs[3].exp_n = {32'h0, 32'hFFFF8000, 32'h0, 32'h00010000, 32'h0};
    vecs[3].exp_sat = 1'b0;

    vecs[4].init  = {32'h7FFF0000, 32'h80000000, 32'h7FFF0000, 32'h0, 32'h0};
    vecs[4].coef  = 32'h00010000; vecs[4].steps = 16'd1;
    vecs[4].exp_d = {32'h7FFF0000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFF0000, 32'h0};
    vecs[4].exp_n = {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFF0000, 32'h0};
    vecs[4].exp_sat = 1'b1;

    // reset state
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    coef = '0; steps = '0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", {31'b0, busy_d | busy_n}, 32'd0);
    check("rst:done", {31'b0, done_d | done_n}, 32'd0);
    check("rst:sat", {31'b0, sat_d | sat_n}, 32'd0);
    check("rst:step_count", {16'b0, sc_d | sc_n}, 32'd0);
    push_exp('0, '0);
    check_nodes("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // loads, out-of-range write, then asynchronous reset between edges
    load({32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000});
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_addr = 3'd6; #1;
    check("oob:rd6_d", rd_data_d, 32'h0);
    check("oob:rd6_n", rd_data_n, 32'h0);
    push_exp({32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000},
             {32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000});
    check_nodes("loaded");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp('0, '0);
    check_nodes("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table-driven vectors
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].init);
      run_and_check(vecs[v].coef, vecs[v].steps, vecs[v].exp_sat, $sformatf("vec%0d", v));
      push_exp(vecs[v].exp_d, vecs[v].exp_n);
      check_nodes($sformatf("vec%0d", v));
    end

    // sat_flag stays set while idle, then a steps=0 run clears it without touching nodes
    repeat (4) @(posedge clk);
    #1;
    check("sat_hold_d", {31'b0, sat_d}, 32'd1);
    check("sat_hold_n", {31'b0, sat_n}, 32'd1);
    run_and_check(32'h00010000, 16'd0, 1'b0, "steps0");
    check("steps0:busy_after", {31'b0, busy_d | busy_n}, 32'd0);
    push_exp(vecs[4].exp_d, vecs[4].exp_n);
    check_nodes("steps0");

    // start and wr_en pulsed mid-run must be ignored
    load(vecs[1].init);
    start_run(vecs[1].coef, vecs[1].steps);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h00012345;
    coef = 32'h00010000; steps = 16'd1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0; wr_en = 1'b0;
    lat = 6;
    while (done_d !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("disturb:latency", 32'(lat + 1), 32'(3 * N + 1));
    check("disturb:step_count", {16'b0, sc_d}, 32'd3);
    @(posedge clk); #1;
    push_exp(vecs[1].exp_d, vecs[1].exp_n);
    check_nodes("disturb");

    // reset in the third sweep cycle of a steps=4 run
    load(vecs[0].init);
    start_run(32'h00004000, 16'd4);
    repeat (2) begin @(posedge clk); #1; end
    check("midrst:busy_before", {31'b0, busy_d}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst:busy_d", {31'b0, busy_d}, 32'd0);
    check("midrst:busy_n", {31'b0, busy_n}, 32'd0);
    check("midrst:step_count", {16'b0, sc_d | sc_n}, 32'd0);
    push_exp('0, '0);
    check_nodes("midrst");
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_d || done_n) done_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_d || done_n) done_seen++;
    end
    check("midrst:no_done", 32'(done_seen), 32'd0);
    load(vecs[0].init);
    run_and_check(vecs[0].coef, vecs[0].steps, 1'b0, "after_rst");
    push_exp(vecs[0].exp_d, vecs[0].exp_n);
    check_nodes("after_rst");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
